// File: rtl/pin_motion_if.sv
// pin_motion_if: bus between the pin kinematics stage and its neighbours.
//   Collision side : coll_valid, pins_vx_in, pins_vy_in, pins_hit_in
//   Control        : rack_in (re-rack), step_in (frame step request)
//   Results        : pins_x, pins_y, pins_knocked, pins_out, busy, valid_out
// master drives requests/collision data, slave is the kinematics stage.
interface pin_motion_if;
    logic              rack_in;
    logic              coll_valid;
    logic [9:0][15:0]  pins_vx_in;
    logic [9:0][15:0]  pins_vy_in;
    logic [9:0]        pins_hit_in;
    logic              step_in;
    logic [9:0][10:0]  pins_x;
    logic [9:0][9:0]   pins_y;
    logic [9:0]        pins_knocked;
    logic [9:0]        pins_out;
    logic              busy;
    logic              valid_out;

    modport master (
        output rack_in, coll_valid, pins_vx_in, pins_vy_in, pins_hit_in, step_in,
        input  pins_x, pins_y, pins_knocked, pins_out, busy, valid_out
    );

    modport slave (
        input  rack_in, coll_valid, pins_vx_in, pins_vy_in, pins_hit_in, step_in,
        output pins_x, pins_y, pins_knocked, pins_out, busy, valid_out
    );
endinterface

// File: rtl/pin_motion.sv
// pin_motion: per-pin kinematics for the ten bowling pins.
// Latches post-collision velocities, and on each frame step integrates
// velocity into position one pin per cycle, applies rolling friction and
// retires pins that leave the screen. A coherent position snapshot is
// published together with a one-cycle valid_out pulse.
// Ports:
//   clk_in  : system clock
//   rst_in  : asynchronous active-high reset (returns everything to the rack)
//   bus     : pin_motion_if.slave (collision inputs, step/rack requests,
//             position snapshot, sticky knocked/out flags, busy, valid_out)
// Build option: define PIN_FRICTION_EN to enable rolling friction; without
// it velocities stay constant until a pin leaves the screen or a re-rack.
module pin_motion #(
    parameter int SCREEN_WIDTH   = 1024,
    parameter int SCREEN_HEIGHT  = 768,
    parameter int HEAD_X         = 512,
    parameter int HEAD_Y         = 200,
    parameter int PIN_SPACING    = 24,
    parameter int ROW_GAP        = 42,
    parameter int FRICTION_SHIFT = 5,
    parameter int STOP_THRESH    = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    pin_motion_if.slave  bus
);

`ifdef PIN_FRICTION_EN
    localparam bit FRICTION_ON = 1'b1;
`else
    localparam bit FRICTION_ON = 1'b0;
`endif

    localparam int                NPINS  = 10;
    localparam logic [11:0]       X_LIM  = 12'(SCREEN_WIDTH);
    localparam logic [10:0]       Y_LIM  = 11'(SCREEN_HEIGHT);
    localparam logic signed [20:0] OFF_X = 21'sh07FF00;
    localparam logic signed [19:0] OFF_Y = 20'sh3FF00;
    localparam logic signed [15:0] STOP_V = 16'(STOP_THRESH);

    typedef enum logic [1:0] {IDLE, LOAD, UPDATE, DONE} state_t;

    state_t state, state_nxt;
    logic [3:0] idx;

    logic signed [20:0] pos_x   [NPINS];
    logic signed [19:0] pos_y   [NPINS];
    logic signed [15:0] vel_x   [NPINS];
    logic signed [15:0] vel_y   [NPINS];
    logic signed [15:0] pend_vx [NPINS];
    logic signed [15:0] pend_vy [NPINS];
    logic [9:0]         hit_pend;
    logic [9:0]         gone;

    logic signed [20:0] sum_x, upd_x;
    logic signed [19:0] sum_y, upd_y;
    logic signed [15:0] upd_vx, upd_vy;
    logic               upd_gone, off;

    // Rack geometry: rows hold 1,2,3,4 pins; row r starts at pin r(r+1)/2.
    function automatic int rack_row(input int i);
        if (i < 1)      return 0;
        else if (i < 3) return 1;
        else if (i < 6) return 2;
        else            return 3;
    endfunction

    function automatic int rack_col(input int i);
        int r;
        int k;
        r = rack_row(i);
        k = i - (r * (r + 1)) / 2;
        return HEAD_X + (2 * k - r) * PIN_SPACING;
    endfunction

    function automatic int rack_line(input int i);
        return HEAD_Y - rack_row(i) * ROW_GAP;
    endfunction

    function automatic logic signed [20:0] sext_x(input logic signed [15:0] v);
        return {{5{v[15]}}, v};
    endfunction

    function automatic logic signed [19:0] sext_y(input logic signed [15:0] v);
        return {{4{v[15]}}, v};
    endfunction

    // Rolling friction: exponential decay, snapping slow pins to rest.
    function automatic logic signed [15:0] friction(input logic signed [15:0] v);
        logic signed [15:0] d;
        d = v - (v >>> FRICTION_SHIFT);
        if (!FRICTION_ON)
            return v;
        if (d > -STOP_V && d < STOP_V)
            return '0;
        return d;
    endfunction

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= (state == UPDATE && state_nxt == UPDATE) ? idx + 4'd1 : '0;
        end
    end

    // Next-state logic; step_in outside IDLE is dropped
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.step_in) state_nxt = LOAD;
            LOAD:    state_nxt = UPDATE;
            UPDATE:  if (idx == 4'd9) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.rack_in)
            state_nxt = IDLE;
    end

    // Outputs decoded from state
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.valid_out = (state == DONE);
    end

    // Integration for the pin selected by idx
    always_comb begin
        sum_x    = pos_x[idx] + sext_x(vel_x[idx]);
        sum_y    = pos_y[idx] + sext_y(vel_y[idx]);
        off      = sum_x[20] || (sum_x[19:8] >= X_LIM) ||
                   sum_y[19] || (sum_y[18:8] >= Y_LIM);
        upd_x    = pos_x[idx];
        upd_y    = pos_y[idx];
        upd_vx   = vel_x[idx];
        upd_vy   = vel_y[idx];
        upd_gone = gone[idx];
        if (!gone[idx]) begin
            if (off) begin
                upd_x    = OFF_X;
                upd_y    = OFF_Y;
                upd_vx   = '0;
                upd_vy   = '0;
                upd_gone = 1'b1;
            end else begin
                upd_x    = sum_x;
                upd_y    = sum_y;
                upd_vx   = friction(vel_x[idx]);
                upd_vy   = friction(vel_y[idx]);
            end
        end
    end

    // Pin state, pending buffer and published snapshot
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NPINS; i++) begin
                pos_x[i]       <= 21'(rack_col(i) * 256);
                pos_y[i]       <= 20'(rack_line(i) * 256);
                vel_x[i]       <= '0;
                vel_y[i]       <= '0;
                pend_vx[i]     <= '0;
                pend_vy[i]     <= '0;
                bus.pins_x[i]  <= 11'(rack_col(i));
                bus.pins_y[i]  <= 10'(rack_line(i));
            end
            hit_pend         <= '0;
            gone             <= '0;
            bus.pins_knocked <= '0;
            bus.pins_out     <= '0;
        end else if (bus.rack_in) begin
            for (int i = 0; i < NPINS; i++) begin
                pos_x[i]       <= 21'(rack_col(i) * 256);
                pos_y[i]       <= 20'(rack_line(i) * 256);
                vel_x[i]       <= '0;
                vel_y[i]       <= '0;
                pend_vx[i]     <= '0;
                pend_vy[i]     <= '0;
                bus.pins_x[i]  <= 11'(rack_col(i));
                bus.pins_y[i]  <= 10'(rack_line(i));
            end
            hit_pend         <= '0;
            gone             <= '0;
            bus.pins_knocked <= '0;
            bus.pins_out     <= '0;
        end else begin
            if (state == LOAD) begin
                for (int i = 0; i < NPINS; i++) begin
                    if (hit_pend[i]) begin
                        vel_x[i] <= pend_vx[i];
                        vel_y[i] <= pend_vy[i];
                    end
                end
            end

            if (state == UPDATE) begin
                pos_x[idx] <= upd_x;
                pos_y[idx] <= upd_y;
                vel_x[idx] <= upd_vx;
                vel_y[idx] <= upd_vy;
                gone[idx]  <= upd_gone;
            end

            // Snapshot is taken on the last update so it is visible in DONE;
            // pin 9 comes from the update path, the rest from working state.
            if (state == UPDATE && idx == 4'd9) begin
                for (int i = 0; i < NPINS - 1; i++) begin
                    bus.pins_x[i] <= pos_x[i][18:8];
                    bus.pins_y[i] <= pos_y[i][17:8];
                end
                bus.pins_x[NPINS-1] <= upd_x[18:8];
                bus.pins_y[NPINS-1] <= upd_y[17:8];
                bus.pins_out        <= {upd_gone, gone[8:0]};
            end

            // A collision landing during LOAD survives the clear for next sweep
            hit_pend <= (state == LOAD ? 10'd0 : hit_pend) |
                        (bus.coll_valid ? bus.pins_hit_in : 10'd0);
            if (bus.coll_valid) begin
                for (int i = 0; i < NPINS; i++) begin
                    if (bus.pins_hit_in[i]) begin
                        pend_vx[i] <= bus.pins_vx_in[i];
                        pend_vy[i] <= bus.pins_vy_in[i];
                    end
                end
                bus.pins_knocked <= bus.pins_knocked | bus.pins_hit_in;
            end
        end
    end

endmodule

// File: tb/tb_pin_motion.sv
// tb_pin_motion: directed bench for pin_motion with hand-computed expectations.
module tb_pin_motion;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   lat, np, ba, idle_pulses;

`ifdef PIN_FRICTION_EN
    localparam int X0_STEP2 = 513;
`else
    localparam int X0_STEP2 = 514;
`endif

    pin_motion_if bus();

    pin_motion dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic hit_pin(input int pin, input logic [15:0] vx, input logic [15:0] vy);
        @(negedge clk);
        bus.pins_hit_in      = 10'(1 << pin);
        bus.pins_vx_in[pin]  = vx;
        bus.pins_vy_in[pin]  = vy;
        bus.coll_valid       = 1'b1;
        @(negedge clk);
        bus.coll_valid       = 1'b0;
        bus.pins_hit_in      = '0;
    endtask

    // Issues one step (cycle 0) and watches 30 cycles; optional collision,
    // duplicate step and rack at given cycle numbers (0 = none).
    task automatic run_step(input int coll_cyc, input int coll_pin,
                            input logic [15:0] cvx, input logic [15:0] cvy,
                            input int dup_cyc, input int rack_cyc,
                            output int latency, output int pulses, output int busy_after);
        latency = -1;
        pulses = 0;
        busy_after = -1;
        @(negedge clk);
        bus.step_in = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            bus.step_in    = (c == dup_cyc);
            bus.rack_in    = (c == rack_cyc);
            bus.coll_valid = (c == coll_cyc);
            if (c == coll_cyc) begin
                bus.pins_hit_in          = 10'(1 << coll_pin);
                bus.pins_vx_in[coll_pin] = cvx;
                bus.pins_vy_in[coll_pin] = cvy;
            end else begin
                bus.pins_hit_in = '0;
            end
            if (bus.valid_out) begin
                pulses++;
                if (latency < 0) latency = c;
            end
            if (c == rack_cyc + 1) busy_after = int'(bus.busy);
        end
        bus.step_in    = 1'b0;
        bus.rack_in    = 1'b0;
        bus.coll_valid = 1'b0;
        bus.pins_hit_in = '0;
    endtask

    initial begin
        bus.rack_in     = 1'b0;
        bus.coll_valid  = 1'b0;
        bus.pins_vx_in  = '0;
        bus.pins_vy_in  = '0;
        bus.pins_hit_in = '0;
        bus.step_in     = 1'b0;

        // Reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.valid_out) idle_pulses++;
        end
        check("rst_x0", int'(bus.pins_x[0]), 512);
        check("rst_y0", int'(bus.pins_y[0]), 200);
        check("rst_x6", int'(bus.pins_x[6]), 440);
        check("rst_y6", int'(bus.pins_y[6]), 74);
        check("rst_x9", int'(bus.pins_x[9]), 584);
        check("rst_out", int'(bus.pins_out), 0);
        check("rst_knocked", int'(bus.pins_knocked), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("idle_valid", idle_pulses, 0);

        // Single hit on pin 0, one step
        hit_pin(0, 16'h0100, 16'hFE00);
        check("knock_now", int'(bus.pins_knocked), 10'h001);
        run_step(0, 0, 16'h0, 16'h0, 0, 0, lat, np, ba);
        check("latency", lat, 12);
        check("pulses1", np, 1);
        check("s1_x0", int'(bus.pins_x[0]), 513);
        check("s1_y0", int'(bus.pins_y[0]), 198);
        check("s1_x1", int'(bus.pins_x[1]), 488);
        check("s1_y1", int'(bus.pins_y[1]), 158);
        check("s1_knocked", int'(bus.pins_knocked), 10'h001);
        check("s1_busy", int'(bus.busy), 0);

        // Second step; a step in the valid_out cycle is dropped
        run_step(0, 0, 16'h0, 16'h0, 12, 0, lat, np, ba);
        check("b2b_pulses", np, 1);
        check("s2_x0", int'(bus.pins_x[0]), X0_STEP2);
        check("s2_y0", int'(bus.pins_y[0]), 196);

        // Pin 6 driven off the top of the screen
        hit_pin(6, 16'h0000, 16'h8000);
        run_step(0, 0, 16'h0, 16'h0, 0, 0, lat, np, ba);
        check("off_out", int'(bus.pins_out), 10'h040);
        check("off_x6", int'(bus.pins_x[6]), 2047);
        check("off_y6", int'(bus.pins_y[6]), 1023);
        run_step(0, 0, 16'h0, 16'h0, 0, 0, lat, np, ba);
        check("held_x6", int'(bus.pins_x[6]), 2047);
        check("held_y6", int'(bus.pins_y[6]), 1023);
        check("held_out", int'(bus.pins_out), 10'h040);

        // Collision mid-sweep for pin 3, plus a step while busy
        run_step(5, 3, 16'h0200, 16'h0000, 4, 0, lat, np, ba);
        check("busy_step_pulses", np, 1);
        check("mid_x3", int'(bus.pins_x[3]), 464);
        check("mid_knocked", int'(bus.pins_knocked), 10'h049);
        run_step(0, 0, 16'h0, 16'h0, 0, 0, lat, np, ba);
        check("next_x3", int'(bus.pins_x[3]), 466);
        check("next_y3", int'(bus.pins_y[3]), 116);

        // Re-rack in the middle of a sweep
        run_step(0, 0, 16'h0, 16'h0, 0, 6, lat, np, ba);
        check("rack_pulses", np, 0);
        check("rack_busy", ba, 0);
        check("rack_x0", int'(bus.pins_x[0]), 512);
        check("rack_y0", int'(bus.pins_y[0]), 200);
        check("rack_x6", int'(bus.pins_x[6]), 440);
        check("rack_y6", int'(bus.pins_y[6]), 74);
        check("rack_x3", int'(bus.pins_x[3]), 464);
        check("rack_knocked", int'(bus.pins_knocked), 0);
        check("rack_out", int'(bus.pins_out), 0);

        // Collision in the LOAD cycle is kept for the following sweep
        run_step(1, 2, 16'h0100, 16'h0000, 0, 0, lat, np, ba);
        check("load_lat", lat, 12);
        check("load_x2", int'(bus.pins_x[2]), 536);
        check("load_x0", int'(bus.pins_x[0]), 512);
        run_step(0, 0, 16'h0, 16'h0, 0, 0, lat, np, ba);
        check("load_next_x2", int'(bus.pins_x[2]), 537);

        // Asynchronous reset in the middle of a sweep
        @(negedge clk);
        bus.step_in = 1'b1;
        @(negedge clk);
        bus.step_in = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(bus.busy), 0);
        check("arst_x2", int'(bus.pins_x[2]), 536);
        check("arst_knocked", int'(bus.pins_knocked), 0);
        @(negedge clk);
        rst = 1'b0;
        run_step(0, 0, 16'h0, 16'h0, 0, 0, lat, np, ba);
        check("arst_lat", lat, 12);
        check("arst_after_x2", int'(bus.pins_x[2]), 536);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
